// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Fabric-side supervisor for the ECP5 EHXPLLL. Pulses the PLL RST input,
// waits for a stable LOCK, then releases the TMDS-domain reset and, after a
// short gap, the pixel-domain reset. A lock loss while running asserts both
// resets again and is counted. A lock that never arrives re-resets the PLL.
// Runs from the 25 MHz board clock, which stays alive while the PLL is unlocked.
//
// Build option: define LOCK_GLITCH_FILTER_EN to ignore lock dropouts shorter
// than four cycles while in RELEASE or RUN. Without it, a single unlocked
// cycle is treated as a loss.

module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP    = 16,
    parameter int LOCK_TIMEOUT   = 250000,
    parameter int PLL_RST_CYCLES = 32,
    parameter int CNT_W          = 8
) (
    input  logic             clk_25MHz,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             clear_stats,
    output logic             pll_rst,
    output logic             rst_tmds_n,
    output logic             rst_pix_n,
    output logic             pll_ok,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic             timeout_seen
);

    // Each counter runs 0 .. limit-1, so $clog2(limit) bits suffice (min 1).
    localparam int RST_W  = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int TO_W   = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;
    localparam int STAB_W = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int REL_W  = (RELEASE_GAP    > 1) ? $clog2(RELEASE_GAP)    : 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Reject illegal parameterisations at elaboration time.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pll_lock_supervisor: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("pll_lock_supervisor: STABLE_CYCLES must be at least 1");
    end
    if (RELEASE_GAP < 1) begin : g_bad_gap
        $error("pll_lock_supervisor: RELEASE_GAP must be at least 1");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
        $error("pll_lock_supervisor: LOCK_TIMEOUT must be at least 1");
    end
    if (PLL_RST_CYCLES < 1) begin : g_bad_rst
        $error("pll_lock_supervisor: PLL_RST_CYCLES must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("pll_lock_supervisor: CNT_W must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_LOSS      = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lk_s;
    logic                   loss_s;
    logic                   timeout_hit_s;
    logic                   loss_evt_s;
    logic [RST_W-1:0]       rst_cnt_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic [STAB_W-1:0]      stab_cnt_r;
    logic [REL_W-1:0]       rel_cnt_r;
    logic                   pll_rst_r;
    logic                   rst_tmds_n_r;
    logic                   rst_pix_n_r;
    logic                   pll_ok_r;
    logic [CNT_W-1:0]       loss_cnt_r;
    logic                   timeout_seen_r;

    // Bring the asynchronous PLL LOCK into the board clock domain.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], locked};
        end
    end

    assign lk_s = sync_r[SYNC_STAGES-1];

`ifdef LOCK_GLITCH_FILTER_EN
    logic [1:0] filt_cnt_r;

    // A loss is only declared on the fourth consecutive unlocked cycle.
    assign loss_s = !lk_s && (filt_cnt_r == 2'd3);

    // Count consecutive unlocked cycles while the downstream logic is released.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_r <= 2'd0;
        end else if ((state_r == ST_RELEASE || state_r == ST_RUN) && !lk_s && !loss_s) begin
            filt_cnt_r <= filt_cnt_r + 2'd1;
        end else begin
            filt_cnt_r <= 2'd0;
        end
    end
`else
    assign loss_s = !lk_s;
`endif

    // Current state register.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_PLL_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; also flags a lock-timeout expiry.
    always_comb begin
        next_state_s  = state_r;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_PLL_RESET: begin
                if (rst_cnt_r == RST_LAST) begin
                    next_state_s = ST_WAIT_LOCK;
                end else begin
                    next_state_s = ST_PLL_RESET;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    next_state_s = ST_STABLE;
                end else if (to_cnt_r == TO_LAST) begin
                    next_state_s  = ST_PLL_RESET;
                    timeout_hit_s = 1'b1;
                end else begin
                    next_state_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                // A dropout here is not a loss: lock simply was not stable yet.
                if (!lk_s) begin
                    next_state_s = ST_WAIT_LOCK;
                end else if (stab_cnt_r == STAB_LAST) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_STABLE;
                end
            end
            ST_RELEASE: begin
                if (loss_s) begin
                    next_state_s = ST_LOSS;
                end else if (rel_cnt_r == REL_LAST) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_RELEASE;
                end
            end
            ST_RUN: begin
                if (loss_s) begin
                    next_state_s = ST_LOSS;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_LOSS: begin
                next_state_s = ST_WAIT_LOCK;
            end
            default: begin
                next_state_s = ST_PLL_RESET;
            end
        endcase
    end

    // LOSS is only ever entered from RELEASE or RUN, so entry marks one event.
    assign loss_evt_s = (next_state_s == ST_LOSS);

    // PLL reset pulse width counter; zero whenever the pulse is not running.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_r <= {RST_W{1'b0}};
        end else if (state_r == ST_PLL_RESET && next_state_s == ST_PLL_RESET) begin
            rst_cnt_r <= rst_cnt_r + RST_W'(1);
        end else begin
            rst_cnt_r <= {RST_W{1'b0}};
        end
    end

    // Lock timeout counter; restarts on every entry to WAIT_LOCK.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_WAIT_LOCK && next_state_s == ST_WAIT_LOCK) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Consecutive-locked counter; any dropout sends the FSM away and clears it.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt_r <= {STAB_W{1'b0}};
        end else if (state_r == ST_STABLE && next_state_s == ST_STABLE) begin
            stab_cnt_r <= stab_cnt_r + STAB_W'(1);
        end else begin
            stab_cnt_r <= {STAB_W{1'b0}};
        end
    end

    // Gap counter between TMDS and pixel reset release.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            rel_cnt_r <= {REL_W{1'b0}};
        end else if (state_r == ST_RELEASE && next_state_s == ST_RELEASE) begin
            rel_cnt_r <= rel_cnt_r + REL_W'(1);
        end else begin
            rel_cnt_r <= {REL_W{1'b0}};
        end
    end

    // Registered outputs decoded from the next state, so they track the state.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_r    <= 1'b1;
            rst_tmds_n_r <= 1'b0;
            rst_pix_n_r  <= 1'b0;
            pll_ok_r     <= 1'b0;
        end else begin
            pll_rst_r    <= (next_state_s == ST_PLL_RESET);
            rst_tmds_n_r <= (next_state_s == ST_RELEASE) || (next_state_s == ST_RUN);
            rst_pix_n_r  <= (next_state_s == ST_RUN);
            pll_ok_r     <= (next_state_s == ST_RUN);
        end
    end

    // Saturating lock-loss counter; a coincident clear keeps the new event.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_r <= {CNT_W{1'b0}};
        end else if (clear_stats) begin
            loss_cnt_r <= loss_evt_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (loss_evt_s && (loss_cnt_r != CNT_MAX)) begin
            loss_cnt_r <= loss_cnt_r + CNT_W'(1);
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    // Sticky timeout flag; a coincident clear keeps the new expiry.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            timeout_seen_r <= 1'b0;
        end else if (timeout_hit_s) begin
            timeout_seen_r <= 1'b1;
        end else if (clear_stats) begin
            timeout_seen_r <= 1'b0;
        end else begin
            timeout_seen_r <= timeout_seen_r;
        end
    end

    assign pll_rst         = pll_rst_r;
    assign rst_tmds_n      = rst_tmds_n_r;
    assign rst_pix_n       = rst_pix_n_r;
    assign pll_ok          = pll_ok_r;
    assign lock_loss_count = loss_cnt_r;
    assign timeout_seen    = timeout_seen_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with small timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_pll_lock_supervisor;

    localparam int CNT_W = 8;
`ifdef LOCK_GLITCH_FILTER_EN
    localparam int LOSS_LAT = 6;
`else
    localparam int LOSS_LAT = 3;
`endif

    logic             clk_25MHz;
    logic             rst_n;
    logic             locked;
    logic             clear_stats;
    logic             pll_rst;
    logic             rst_tmds_n;
    logic             rst_pix_n;
    logic             pll_ok;
    logic [CNT_W-1:0] lock_loss_count;
    logic             timeout_seen;

    int n_checks;
    int n_pass;

    pll_lock_supervisor #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (8),
        .RELEASE_GAP    (4),
        .LOCK_TIMEOUT   (100),
        .PLL_RST_CYCLES (5),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_25MHz       (clk_25MHz),
        .rst_n           (rst_n),
        .locked          (locked),
        .clear_stats     (clear_stats),
        .pll_rst         (pll_rst),
        .rst_tmds_n      (rst_tmds_n),
        .rst_pix_n       (rst_pix_n),
        .pll_ok          (pll_ok),
        .lock_loss_count (lock_loss_count),
        .timeout_seen    (timeout_seen)
    );

    initial clk_25MHz = 1'b0;
    always #5 clk_25MHz = ~clk_25MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk_25MHz);
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (pll_ok !== 1'b1 && n < 80) begin
            adv(1);
            n++;
        end
        if (pll_ok !== 1'b1) check(tag, 32'(pll_ok), 32'd1);
    endtask

    // One lock loss from RUN: long enough to trip the filter in either build.
    task automatic loss_event();
        locked = 1'b0;
        adv(6);
        locked = 1'b1;
        wait_run("loss_rerun");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_rel;
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        locked      = 1'b0;
        clear_stats = 1'b0;
        adv(2);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_tmds_n", 32'(rst_tmds_n), 32'd0);
        check("rst_pix_n", 32'(rst_pix_n), 32'd0);
        check("rst_pll_ok", 32'(pll_ok), 32'd0);
        check("rst_count", 32'(lock_loss_count), 32'd0);
        check("rst_timeout", 32'(timeout_seen), 32'd0);

        // Lock never arrives: 5-cycle PLL reset, 100-cycle wait, then re-reset.
        rst_n = 1'b1;
        adv(4);
        check("t1_prst_hi", 32'(pll_rst), 32'd1);
        adv(1);
        check("t1_prst_lo", 32'(pll_rst), 32'd0);
        any_rel = 1'b0;
        for (int i = 6; i <= 104; i++) begin
            adv(1);
            if (rst_tmds_n || rst_pix_n) any_rel = 1'b1;
        end
        check("t1_wait_end", 32'(pll_rst), 32'd0);
        check("t1_no_to_yet", 32'(timeout_seen), 32'd0);
        adv(1);
        check("t1_prst_again", 32'(pll_rst), 32'd1);
        check("t1_timeout", 32'(timeout_seen), 32'd1);
        check("t1_held", 32'(any_rel), 32'd0);
        clear_stats = 1'b1;
        adv(1);
        clear_stats = 1'b0;
        check("t1_to_clear", 32'(timeout_seen), 32'd0);

        // Lock present from reset: normal release sequence.
        rst_n  = 1'b0;
        locked = 1'b1;
        adv(2);
        rst_n = 1'b1;
        adv(5);
        check("t2_prst_lo", 32'(pll_rst), 32'd0);
        adv(8);
        check("t2_tmds_lo", 32'(rst_tmds_n), 32'd0);
        adv(1);
        check("t2_tmds_hi", 32'(rst_tmds_n), 32'd1);
        check("t2_pix_lo0", 32'(rst_pix_n), 32'd0);
        adv(3);
        check("t2_pix_lo", 32'(rst_pix_n), 32'd0);
        check("t2_ok_lo", 32'(pll_ok), 32'd0);
        adv(1);
        check("t2_pix_hi", 32'(rst_pix_n), 32'd1);
        check("t2_ok_hi", 32'(pll_ok), 32'd1);

        // One-cycle dropout at stability count 5 restarts the stability wait.
        rst_n = 1'b0;
        adv(2);
        rst_n = 1'b1;
        adv(9);
        locked = 1'b0;
        adv(1);
        locked = 1'b1;
        adv(10);
        check("t3_tmds_lo", 32'(rst_tmds_n), 32'd0);
        adv(1);
        check("t3_tmds_hi", 32'(rst_tmds_n), 32'd1);
        adv(3);
        check("t3_pix_lo", 32'(rst_pix_n), 32'd0);
        adv(1);
        check("t3_pix_hi", 32'(rst_pix_n), 32'd1);
        check("t3_count", 32'(lock_loss_count), 32'd0);

        // Dropouts while in RUN.
        adv(2);
`ifdef LOCK_GLITCH_FILTER_EN
        locked = 1'b0;
        adv(1);
        locked = 1'b1;
        adv(2);
        check("t4_glitch_tmds", 32'(rst_tmds_n), 32'd1);
        check("t4_glitch_ok", 32'(pll_ok), 32'd1);
        check("t4_glitch_cnt", 32'(lock_loss_count), 32'd0);
        adv(2);
        locked = 1'b0;
        adv(4);
        locked = 1'b1;
        adv(1);
        check("t4_drop4_tmds_hi", 32'(rst_tmds_n), 32'd1);
        adv(1);
        check("t4_drop4_tmds_lo", 32'(rst_tmds_n), 32'd0);
        check("t4_drop4_cnt", 32'(lock_loss_count), 32'd1);
        wait_run("t4_rerun");
`else
        locked = 1'b0;
        adv(1);
        locked = 1'b1;
        adv(1);
        check("t4_tmds_still", 32'(rst_tmds_n), 32'd1);
        adv(1);
        check("t4_tmds_lo", 32'(rst_tmds_n), 32'd0);
        check("t4_pix_lo", 32'(rst_pix_n), 32'd0);
        check("t4_ok_lo", 32'(pll_ok), 32'd0);
        check("t4_count", 32'(lock_loss_count), 32'd1);
        adv(9);
        check("t4_re_tmds_lo", 32'(rst_tmds_n), 32'd0);
        adv(1);
        check("t4_re_tmds_hi", 32'(rst_tmds_n), 32'd1);
        adv(4);
        check("t4_re_pix_hi", 32'(rst_pix_n), 32'd1);
        check("t4_re_ok_hi", 32'(pll_ok), 32'd1);
        check("t4_re_count", 32'(lock_loss_count), 32'd1);
`endif

        // Saturation: 1 + 254 reaches 255, further events hold it there.
        for (int i = 0; i < 254; i++) loss_event();
        check("t5_reach_max", 32'(lock_loss_count), 32'd255);
        for (int i = 0; i < 46; i++) loss_event();
        check("t5_saturated", 32'(lock_loss_count), 32'd255);
        clear_stats = 1'b1;
        adv(1);
        clear_stats = 1'b0;
        check("t5_clear", 32'(lock_loss_count), 32'd0);

        // clear_stats on the loss edge leaves exactly one event counted.
        loss_event();
        check("t6_one", 32'(lock_loss_count), 32'd1);
        locked = 1'b0;
        adv(LOSS_LAT - 1);
        clear_stats = 1'b1;
        adv(1);
        clear_stats = 1'b0;
        check("t6_clr_loss", 32'(lock_loss_count), 32'd1);
        check("t6_tmds_lo", 32'(rst_tmds_n), 32'd0);
        locked = 1'b1;
        wait_run("t6_rerun");

        // Asynchronous reset while running.
        check("t7_pre_ok", 32'(pll_ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_pll_rst", 32'(pll_rst), 32'd1);
        check("t7_tmds", 32'(rst_tmds_n), 32'd0);
        check("t7_pix", 32'(rst_pix_n), 32'd0);
        check("t7_ok", 32'(pll_ok), 32'd0);
        check("t7_count", 32'(lock_loss_count), 32'd0);
        check("t7_timeout", 32'(timeout_seen), 32'd0);
        adv(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
